oscillator_unit: RTL and testbench

OSCILLATOR_UNIT -- requirements
Module: oscillator_unit

---
 rtl/oscillator_unit_pkg.sv | 49 ++++
 rtl/oscillator_unit_sampling_control.sv | 63 ++++++
 rtl/oscillator_unit.sv | 57 +++++
 tb/tb_oscillator_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oscillator_unit_pkg.sv
// Shared constants, divider table and state payload for the sample-rate oscillator.
package oscillator_unit_pkg;

  localparam int unsigned MODE_W    = 4;
  localparam int unsigned CNT_W     = 12;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned FRAC_BITS = 30;

  localparam logic signed [DATA_W-1:0] EPS_DEFAULT = 32'sd6_588_397;

  localparam logic [MODE_W-1:0] MODE_OFF  = 4'd0;
  localparam logic [MODE_W-1:0] MODE_48K  = 4'd1;
  localparam logic [MODE_W-1:0] MODE_96K  = 4'd2;
  localparam logic [MODE_W-1:0] MODE_192K = 4'd3;
  localparam logic [MODE_W-1:0] MODE_8K   = 4'd4;

  localparam logic [CNT_W-1:0] DIV_48K  = 12'd500;
  localparam logic [CNT_W-1:0] DIV_96K  = 12'd250;
  localparam logic [CNT_W-1:0] DIV_192K = 12'd125;
  localparam logic [CNT_W-1:0] DIV_8K   = 12'd3000;

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
  } osc_state_t;

  // Sample divider in Fg_CLK cycles; the OFF/illegal entry is never used for timing.
  function automatic logic [CNT_W-1:0] div_of(input logic [MODE_W-1:0] m);
    case (m)
      MODE_48K:  return DIV_48K;
      MODE_96K:  return DIV_96K;
      MODE_192K: return DIV_192K;
      MODE_8K:   return DIV_8K;
      default:   return DIV_48K;
    endcase
  endfunction

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    case (m)
      MODE_OFF:  return MODE_48K;
      MODE_48K:  return MODE_96K;
      MODE_96K:  return MODE_192K;
      MODE_192K: return MODE_8K;
      default:   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/oscillator_unit_sampling_control.sv
// Button edge detect, mode sequencing, sample divider and Ready strobe generation.
module sampling_control
  import oscillator_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  output logic              ready,
  output logic              enable,
  output logic [MODE_W-1:0] mode
);

  logic              btn_q, btn_d;
  logic              arm_q, arm_d;
  logic              ready_q, ready_d;
  logic              enable_q, enable_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press;

  // arm stays low until the button is seen released, so a press held through reset is ignored
  always_comb begin
    btn_d    = btn;
    arm_d    = arm_q | ~btn;
    press    = btn & ~btn_q & arm_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q + CNT_W'(1);
    ready_d  = 1'b0;
    if (press) begin
      mode_d = next_mode(mode_q);
    end
    enable_d = (mode_d != MODE_OFF);
    if (press || !enable_q) begin
      cnt_d = '0;
    end else if (cnt_q == div_of(mode_q) - CNT_W'(1)) begin
      cnt_d   = '0;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= 1'b0;
      arm_q    <= 1'b0;
      ready_q  <= 1'b0;
      enable_q <= 1'b0;
      mode_q   <= MODE_OFF;
      cnt_q    <= '0;
    end else begin
      btn_q    <= btn_d;
      arm_q    <= arm_d;
      ready_q  <= ready_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready  = ready_q;
  assign enable = enable_q;
  assign mode   = mode_q;

endmodule

// File: rtl/oscillator_unit.sv
// Quadrature rotation oscillator stepped once per Ready strobe at a button-selected rate.
module oscillator_unit
  import oscillator_unit_pkg::*;
#(
  parameter logic signed [DATA_W-1:0] EPS = EPS_DEFAULT
) (
  input  logic                     Fg_CLK,
  input  logic                     RESET,
  input  logic                     IntBTN,
  input  logic signed [DATA_W-1:0] init1,
  input  logic signed [DATA_W-1:0] init2,
  output logic                     Ready,
  output logic                     Enable,
  output logic [MODE_W-1:0]        Mode,
  output logic signed [DATA_W-1:0] out1,
  output logic signed [DATA_W-1:0] out2
);

  osc_state_t               st_q, st_d;
  logic signed [PROD_W-1:0] prod_y, prod_x;
  logic signed [DATA_W-1:0] x_new, y_new;

  sampling_control u_ctrl (
    .clk    (Fg_CLK),
    .rst    (RESET),
    .btn    (IntBTN),
    .ready  (Ready),
    .enable (Enable),
    .mode   (Mode)
  );

  // Y update uses the freshly rotated X so the map stays area-preserving
  always_comb begin
    prod_y = PROD_W'(EPS) * PROD_W'($signed(st_q.y));
    x_new  = $signed(st_q.x) - DATA_W'(prod_y >>> FRAC_BITS);
    prod_x = PROD_W'(EPS) * PROD_W'(x_new);
    y_new  = $signed(st_q.y) + DATA_W'(prod_x >>> FRAC_BITS);
    st_d   = st_q;
    if (!Enable) begin
      st_d = '{x: init1, y: init2};
    end else if (Ready) begin
      st_d = '{x: x_new, y: y_new};
    end
  end

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      st_q <= '{x: init1, y: init2};
    end else begin
      st_q <= st_d;
    end
  end

  assign out1 = st_q.x;
  assign out2 = st_q.y;

endmodule

// File: tb/tb_oscillator_unit.sv
// Self-checking bench: event-level reference model checked every cycle, plus directed sequences.
module tb_oscillator_unit;

  localparam int EPS_V = 6_588_397;
  localparam int INIT1 = 96_878_045;
  localparam int INIT2 = 1_054_193_702;

  logic              clk = 1'b0;
  logic              rst, btn, ready, enable;
  logic [3:0]        mode;
  logic signed [31:0] init1, init2, out1, out2;

  int n_cmp = 0;
  int n_bad = 0;

  oscillator_unit #(.EPS(32'sd6_588_397)) dut (
    .Fg_CLK (clk),
    .RESET  (rst),
    .IntBTN (btn),
    .init1  (init1),
    .init2  (init2),
    .Ready  (ready),
    .Enable (enable),
    .Mode   (mode),
    .out1   (out1),
    .out2   (out2)
  );

  always #5 clk = ~clk;

  // Reference model: mode, cycles since the mode took its value, and oscillator state.
  int m_mode, m_age, m_x, m_y;
  bit m_prev, m_arm;

  function automatic int div_cycles(input int m);
    case (m)
      1: return 500;
      2: return 250;
      3: return 125;
      4: return 3000;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_ready();
    return (m_mode != 0) && (m_age > 0) && ((m_age % div_cycles(m_mode)) == 0);
  endfunction

  function automatic void rotate(inout int x, inout int y);
    longint p;
    p = longint'(EPS_V) * longint'(y);
    x = x - int'(p >>> 30);
    p = longint'(EPS_V) * longint'(x);
    y = y + int'(p >>> 30);
  endfunction

  task automatic model_step(input bit r, input bit b);
    bit pressed;
    if (r) begin
      m_mode = 0; m_age = 0; m_x = init1; m_y = init2; m_prev = 0; m_arm = 0;
      return;
    end
    if (m_mode == 0) begin
      m_x = init1; m_y = init2;
    end else if (m_ready()) begin
      rotate(m_x, m_y);
    end
    pressed = b && !m_prev && m_arm;
    m_arm   = m_arm || !b;
    m_prev  = b;
    if (pressed) begin
      m_mode = (m_mode >= 4) ? 0 : m_mode + 1;
      m_age  = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check(input string name, input longint act, input longint want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  task automatic tick(input bit r, input bit b);
    logic [69:0] want, got;
    rst = r;
    btn = b;
    model_step(r, b);
    @(posedge clk);
    #1;
    want = {m_ready(), (m_mode != 0), 4'(m_mode), 32'(m_x), 32'(m_y)};
    got  = {ready, enable, mode, out1, out2};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL cycle @%0t: got %h, want %h", $time, got, want);
    end
  endtask

  // Returns the number of ticks until Ready is seen, bounded by limit.
  task automatic wait_ready(input int limit, output int n);
    n = 0;
    do begin
      tick(0, 0);
      n++;
    end while (ready !== 1'b1 && n < limit);
  endtask

  typedef struct {
    int hold;
    int exp_mode;
    bit exp_en;
    int exp_div;
  } step_t;

  step_t steps[5];
  int    n, x1, y1, ix, iy, sp_err, hold_left;
  bit    changed;
  real   e0, e, dev;

  initial begin
    steps = '{'{1, 1, 1, 500}, '{1, 2, 1, 250}, '{1, 3, 1, 125}, '{1, 4, 1, 3000}, '{1, 0, 0, 0}};
    init1 = INIT1;
    init2 = INIT2;
    rst   = 1'b1;
    btn   = 1'b0;

    // Reset and idle hold
    repeat (3) tick(1, 0);
    changed = 0;
    for (int i = 0; i < 10000; i++) begin
      tick(0, 0);
      if (out1 !== INIT1 || out2 !== INIT2 || ready !== 1'b0 || enable !== 1'b0 || mode !== 4'd0)
        changed = 1;
    end
    check("rst_hold_changed", changed, 0);
    check("rst_mode", mode, 0);
    check("rst_enable", enable, 0);
    check("rst_ready", ready, 0);
    check("rst_out1", out1, 96_878_045);
    check("rst_out2", out2, 1_054_193_702);

    // Mode sequence table
    for (int i = 0; i < 5; i++) begin
      for (int h = 0; h < steps[i].hold; h++) tick(0, 1);
      check($sformatf("seq%0d_mode", i), mode, steps[i].exp_mode);
      check($sformatf("seq%0d_enable", i), enable, steps[i].exp_en);
      if (steps[i].exp_div != 0) begin
        wait_ready(steps[i].exp_div + 5, n);
        check($sformatf("seq%0d_first_ready", i), n, steps[i].exp_div - steps[i].hold + 1);
        tick(0, 0);
        if (i == 0) begin
          x1 = INIT1; y1 = INIT2;
          rotate(x1, y1);
          check("first_sample_out1", out1, x1);
          check("first_sample_out2", out2, y1);
        end
        wait_ready(steps[i].exp_div + 5, n);
        check($sformatf("seq%0d_spacing", i), n + 1, steps[i].exp_div);
      end else begin
        tick(0, 0);
        check("off_reload_out1", out1, INIT1);
        check("off_reload_out2", out2, INIT2);
        check("off_ready", ready, 0);
      end
    end

    // Held button advances once
    repeat (50) tick(0, 1);
    check("held_mode", mode, 1);
    tick(0, 0);
    wait_ready(600, n);
    check("held_first_ready", n, 450);

    // Press coinciding with Ready: update happens and counter restarts
    x1 = m_x; y1 = m_y;
    rotate(x1, y1);
    tick(0, 1);
    check("press_on_ready_mode", mode, 2);
    check("press_on_ready_out1", out1, x1);
    check("press_on_ready_out2", out2, y1);
    wait_ready(300, n);
    check("press_on_ready_spacing", n, 250);

    // Reset mid-period in mode 2
    repeat (100) tick(0, 0);
    tick(1, 0);
    check("midrst_mode", mode, 0);
    check("midrst_enable", enable, 0);
    check("midrst_ready", ready, 0);
    check("midrst_out1", out1, INIT1);
    check("midrst_out2", out2, INIT2);

    // Button held through reset release is ignored
    tick(1, 1);
    repeat (5) tick(0, 1);
    check("btn_thru_rst_mode", mode, 0);
    tick(0, 0);
    tick(0, 1);
    check("btn_after_release_mode", mode, 1);

    // Return to OFF, then step quickly to mode 3 from the initial phase
    repeat (4) begin tick(0, 0); tick(0, 1); end
    check("back_off_mode", mode, 0);
    repeat (3) tick(0, 0);
    tick(0, 1); tick(0, 0); tick(0, 1); tick(0, 0); tick(0, 1);
    check("lr_mode", mode, 3);

    // Long run: amplitude and quarter-period between X and Y zero crossings
    e0 = real'(INIT1) * real'(INIT1) + real'(INIT2) * real'(INIT2);
    dev = 0.0; ix = -1; iy = -1; sp_err = 0;
    wait_ready(200, n);
    check("lr_first_ready", n, 125);
    for (int s = 1; s <= 300; s++) begin
      tick(0, 0);
      e = (real'(out1) * real'(out1) + real'(out2) * real'(out2)) / e0;
      if (e > 1.0 && e - 1.0 > dev) dev = e - 1.0;
      if (e < 1.0 && 1.0 - e > dev) dev = 1.0 - e;
      if (ix < 0 && out1 < 0) ix = s;
      if (iy < 0 && out2 < 0) iy = s;
      if (s < 300) begin
        wait_ready(200, n);
        if (n != 124) sp_err++;
      end
    end
    check("lr_spacing_errors", sp_err, 0);
    check_range("lr_energy_ppm", longint'(dev * 1.0e6), 0, 20000);
    check_range("lr_x_cross", ix, 10, 20);
    check_range("lr_quarter_period", iy - ix, 250, 262);

    // Randomized presses, resets and initial values against the model
    init1 = $urandom;
    init2 = $urandom;
    hold_left = 0;
    for (int i = 0; i < 8000; i++) begin
      bit r, b;
      r = ($urandom_range(0, 1999) == 0);
      if (hold_left > 0) begin
        hold_left--;
      end else if ($urandom_range(0, 399) == 0) begin
        hold_left = $urandom_range(1, 4);
      end
      b = (hold_left > 0);
      if ($urandom_range(0, 999) == 0) begin
        init1 = $urandom;
        init2 = $urandom;
      end
      tick(r, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
